// File: rtl/accum_pkg.sv
// Shared defaults, FSM state type and FIFO sizing for the accumulator
// column drain engine.
package accum_pkg;

  localparam int ACCUM_ROW_DEF  = 256;
  localparam int DATA_WIDTH_DEF = 32;
  localparam int FIFO_DEPTH     = 4;
  localparam int FIFO_CNT_W     = $clog2(FIFO_DEPTH + 1);
  localparam int FIFO_PTR_W     = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    FLUSH,
    DONE
  } drain_state_e;

endpackage

// File: rtl/accum_drain_fifo.sv
// Small synchronous FIFO of {last, data} beats between the SRAM read return
// and the downstream valid/ready port; occupancy count is registered.
module accum_drain_fifo
  import accum_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  push,
  input  logic                  push_last,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count,
  output logic                  head_last,
  output logic [DATA_WIDTH-1:0] head_data
);

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr_q;
  logic [FIFO_PTR_W-1:0] rd_ptr_q;
  logic [FIFO_CNT_W-1:0] count_q;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && (count_q != FIFO_CNT_W'(FIFO_DEPTH));
  assign do_pop  = pop && (count_q != '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + FIFO_PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + FIFO_PTR_W'(1);
      if (do_push && !do_pop)      count_q <= count_q + FIFO_CNT_W'(1);
      else if (!do_push && do_pop) count_q <= count_q - FIFO_CNT_W'(1);
    end
  end

  // Storage carries no reset; the top masks the head while empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= {push_last, push_data};
  end

  assign empty                  = (count_q == '0);
  assign count                  = count_q;
  assign {head_last, head_data} = mem[rd_ptr_q];

endmodule

// File: rtl/accum_col_drain.sv
// Column SRAM readout: streams a contiguous (wrapping) row range out over
// valid/ready, optionally zeroing each row once its value has been captured.
module accum_col_drain
  import accum_pkg::*;
#(
  parameter  int ACCUM_ROW  = ACCUM_ROW_DEF,
  parameter  int DATA_WIDTH = DATA_WIDTH_DEF,
  localparam int ADDR_WIDTH = $clog2(ACCUM_ROW)
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_row,
  input  logic [ADDR_WIDTH:0]   num_rows,
  input  logic                  clear_en,
  output logic                  busy,
  output logic                  done,
  output logic                  sram_rd_en,
  output logic [ADDR_WIDTH-1:0] sram_rd_addr,
  input  logic [DATA_WIDTH-1:0] sram_rd_data,
  output logic                  sram_wr_en,
  output logic [ADDR_WIDTH-1:0] sram_wr_addr,
  output logic [DATA_WIDTH-1:0] sram_wr_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
);

  function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] a);
    return (a == ADDR_WIDTH'(ACCUM_ROW - 1)) ? '0 : a + ADDR_WIDTH'(1);
  endfunction

  drain_state_e          state_q, state_d;
  logic [ADDR_WIDTH:0]   total_q;
  logic [ADDR_WIDTH:0]   issued_q;
  logic                  clear_q;
  logic [ADDR_WIDTH-1:0] rd_addr_p0;
  logic                  vld_p1;
  logic                  last_p1;
  logic [ADDR_WIDTH-1:0] addr_p1;

  logic                  fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [FIFO_CNT_W-1:0] occ;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  issue;
  logic                  last_issue;
  logic                  accept;

  assign accept = (state_q == IDLE) && start;

  // Occupancy counts the read in flight so a returning word always has a slot.
  assign occ        = fifo_count + FIFO_CNT_W'(vld_p1);
  assign issue      = (state_q == ISSUE) && (issued_q != total_q) &&
                      (occ < FIFO_CNT_W'(FIFO_DEPTH - 1));
  assign last_issue = issue && ((issued_q + (ADDR_WIDTH+1)'(1)) == total_q);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = (num_rows == '0) ? DONE : ISSUE;
      ISSUE:   if (last_issue) state_d = FLUSH;
      FLUSH:   if (fifo_empty && !vld_p1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      total_q  <= '0;
      issued_q <= '0;
      clear_q  <= 1'b0;
      vld_p1   <= 1'b0;
      last_p1  <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_p1  <= issue;
      last_p1 <= last_issue;
      if (accept) begin
        total_q  <= num_rows;
        issued_q <= '0;
        clear_q  <= clear_en;
      end else if (issue) begin
        issued_q <= issued_q + (ADDR_WIDTH+1)'(1);
      end
    end
  end

  // Stage p0 -> p1: read address issued, remembered for the return/clear cycle.
  always_ff @(posedge clk) begin
    if (accept)     rd_addr_p0 <= start_row;
    else if (issue) rd_addr_p0 <= next_addr(rd_addr_p0);
    if (issue)      addr_p1    <= rd_addr_p0;
  end

  // Stage p1: read data returns, is pushed, and its row is cleared.
  accum_drain_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (vld_p1),
    .push_last (last_p1),
    .push_data (sram_rd_data),
    .pop       (out_valid && out_ready),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_last (head_last),
    .head_data (head_data)
  );

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign sram_rd_en   = issue;
  assign sram_rd_addr = issue ? rd_addr_p0 : '0;
  assign sram_wr_en   = vld_p1 && clear_q;
  assign sram_wr_addr = sram_wr_en ? addr_p1 : '0;
  assign sram_wr_data = '0;
  assign out_valid    = !fifo_empty;
  assign out_data     = out_valid ? head_data : '0;
  assign out_last     = out_valid && head_last;

endmodule

// File: tb/tb_accum_col_drain.sv
// Bench for accum_col_drain: table of drain vectors against an SRAM model and
// a beat scoreboard, plus a hand-written mid-drain reset sequence.
module tb_accum_col_drain;

  logic        clk;
  logic        rstn;
  logic        start;
  logic [7:0]  start_row;
  logic [8:0]  num_rows;
  logic        clear_en;
  logic        busy;
  logic        done;
  logic        sram_rd_en;
  logic [7:0]  sram_rd_addr;
  logic [31:0] sram_rd_data;
  logic        sram_wr_en;
  logic [7:0]  sram_wr_addr;
  logic [31:0] sram_wr_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;

  accum_col_drain dut (
    .clk          (clk),
    .rstn         (rstn),
    .start        (start),
    .start_row    (start_row),
    .num_rows     (num_rows),
    .clear_en     (clear_en),
    .busy         (busy),
    .done         (done),
    .sram_rd_en   (sram_rd_en),
    .sram_rd_addr (sram_rd_addr),
    .sram_rd_data (sram_rd_data),
    .sram_wr_en   (sram_wr_en),
    .sram_wr_addr (sram_wr_addr),
    .sram_wr_data (sram_wr_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Column SRAM model: 1-cycle read latency, write counters per row.
  logic [31:0] mem [256];
  int          wr_cnt [256];
  bit          loaded = 1'b0;
  initial sram_rd_data = '0;

  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 256; i++) begin
        mem[i]    <= 32'(10 * (i + 1));
        wr_cnt[i] <= 0;
      end
      loaded <= 1'b1;
    end else begin
      if (sram_rd_en) sram_rd_data <= mem[sram_rd_addr];
      if (sram_wr_en) begin
        mem[sram_wr_addr]    <= sram_wr_data;
        wr_cnt[sram_wr_addr] <= wr_cnt[sram_wr_addr] + 1;
      end
    end
  end

  typedef struct {
    int start_row;
    int num_rows;
    bit clear_en;
    bit bp;
    bit poke;
    int exp_done;
    int exp_first;
  } vec_t;

  typedef struct {
    logic [31:0] d;
    bit          l;
  } beat_t;

  beat_t       exp_q[$];
  logic [31:0] ref_mem [256];
  int n_cmp = 0;
  int n_bad = 0;

  int rel, cur_start;
  int busy_cnt, busy_first, done_cnt, done_rel;
  int rd_cnt, pop_cnt, wr_total, addr_err, stall_err, max_out;
  int first_rel, last_rel;
  bit prev_stall, prev_last;
  logic [31:0] prev_data;

  function automatic void check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endfunction

  task automatic clear_stats();
    busy_cnt = 0; busy_first = -1; done_cnt = 0; done_rel = -1;
    rd_cnt = 0; pop_cnt = 0; wr_total = 0; addr_err = 0; stall_err = 0;
    max_out = 0; first_rel = -1; last_rel = -1;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = '0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_en"}, sram_rd_en, 0);
    check({tag, "_rd_addr"}, sram_rd_addr, 0);
    check({tag, "_wr_en"}, sram_wr_en, 0);
    check({tag, "_wr_addr"}, sram_wr_addr, 0);
    check({tag, "_wr_data"}, sram_wr_data, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_data"}, out_data, 0);
    check({tag, "_out_last"}, out_last, 0);
  endtask

  // Sample one cycle at the falling edge, then advance to just past the rising edge.
  task automatic step();
    int    occ;
    beat_t e;
    @(negedge clk);
    if (busy) begin
      busy_cnt++;
      if (busy_first < 0) busy_first = rel;
    end
    if (done) begin
      done_cnt++;
      done_rel = rel;
    end
    if (sram_rd_en) begin
      if (sram_rd_addr != 8'((cur_start + rd_cnt) % 256)) addr_err++;
      occ = rd_cnt - pop_cnt + 1;
      if (occ > max_out) max_out = occ;
      rd_cnt++;
    end
    if (sram_wr_en) wr_total++;
    if (out_valid && prev_stall && (out_data != prev_data || out_last != prev_last))
      stall_err++;
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_beat", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("beat_data", out_data, e.d);
        check("beat_last", out_last, e.l);
      end
      if (first_rel < 0) first_rel = rel;
      last_rel = rel;
      pop_cnt++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(vec_t v);
    int r, off, bad_mem, bad_wr, expw;
    int wbase [256];
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 256; i++) wbase[i] = wr_cnt[i];
    for (int k = 0; k < v.num_rows; k++) begin
      r = (v.start_row + k) % 256;
      exp_q.push_back('{ref_mem[r], (k == v.num_rows - 1)});
      if (v.clear_en) ref_mem[r] = '0;
    end
    clear_stats();
    cur_start = v.start_row;
    start_row = 8'(v.start_row);
    num_rows  = 9'(v.num_rows);
    clear_en  = v.clear_en;
    start     = 1'b1;
    rel       = 0;
    while (rel < v.num_rows * 4 + 40) begin
      if (rel == 1) start = 1'b0;
      if (v.poke && rel == 4) begin
        start = 1'b1; start_row = 8'd0; num_rows = 9'd1;
      end
      if (v.poke && rel == 5) start = 1'b0;
      out_ready = v.bp ? pat[rel % 4] : 1'b1;
      step();
      if (done_rel >= 0 && rel >= done_rel + 2) break;
      rel++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    check("drain_completed", (done_rel >= 0), 1);
    check("done_pulses", done_cnt, 1);
    if (v.exp_done >= 0) check("done_cycle", done_rel, v.exp_done);
    check("busy_first_cycle", busy_first, 1);
    check("busy_cycles", busy_cnt, done_rel);
    check("reads_issued", rd_cnt, v.num_rows);
    check("beats_out", pop_cnt, v.num_rows);
    check("beats_left", exp_q.size(), 0);
    check("clear_writes", wr_total, v.clear_en ? v.num_rows : 0);
    check("read_addr_order", addr_err, 0);
    check("occupancy_le_3", (max_out <= 3), 1);
    check("stall_stable", stall_err, 0);
    if (v.exp_first >= 0) begin
      check("first_beat_cycle", first_rel, v.exp_first);
      check("last_beat_cycle", last_rel, v.num_rows + 2);
    end
    bad_mem = 0;
    bad_wr  = 0;
    for (int i = 0; i < 256; i++) begin
      if (mem[i] != ref_mem[i]) bad_mem++;
      off  = (i - v.start_row + 256) % 256;
      expw = (v.clear_en && off < v.num_rows) ? 1 : 0;
      if (wr_cnt[i] - wbase[i] != expw) bad_wr++;
    end
    check("sram_contents", bad_mem, 0);
    check("rows_cleared_once", bad_wr, 0);
    exp_q.delete();
  endtask

  vec_t vecs [7];

  initial begin
    rstn      = 1'b0;
    start     = 1'b0;
    start_row = '0;
    num_rows  = '0;
    clear_en  = 1'b0;
    out_ready = 1'b1;
    cur_start = 0;
    rel       = 0;
    clear_stats();
    for (int i = 0; i < 256; i++) ref_mem[i] = 32'(10 * (i + 1));

    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rstn = 1'b1;
    @(posedge clk);
    #1;

    //          start  num  clr   bp    poke  done first
    vecs[0] = '{0,     4,   1'b0, 1'b0, 1'b0, 8,   3};
    vecs[1] = '{254,   4,   1'b1, 1'b0, 1'b0, 8,   3};
    vecs[2] = '{254,   4,   1'b0, 1'b0, 1'b0, 8,   3};
    vecs[3] = '{100,   8,   1'b0, 1'b1, 1'b0, -1,  -1};
    vecs[4] = '{0,     0,   1'b0, 1'b0, 1'b0, 1,   -1};
    vecs[5] = '{30,    6,   1'b0, 1'b0, 1'b1, 10,  3};
    vecs[6] = '{7,     256, 1'b0, 1'b0, 1'b0, 260, 3};
    for (int t = 0; t < 7; t++) run_vec(vecs[t]);

    // Reset asserted mid-drain, after the second beat of six.
    for (int k = 0; k < 6; k++)
      exp_q.push_back('{ref_mem[40 + k], (k == 5)});
    clear_stats();
    cur_start = 40;
    start_row = 8'd40;
    num_rows  = 9'd6;
    clear_en  = 1'b0;
    out_ready = 1'b1;
    start     = 1'b1;
    rel       = 0;
    while (pop_cnt < 2 && rel < 40) begin
      if (rel == 1) start = 1'b0;
      step();
      rel++;
    end
    start = 1'b0;
    check("rst_reached_beat2", pop_cnt, 2);
    check("rst_busy_before", busy, 1);
    rstn = 1'b0;
    #1;
    check_all_zero("midrst");
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check_all_zero("post_rst_idle");
    run_vec('{50, 5, 1'b1, 1'b0, 1'b0, 9, 3});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
